// File: rtl/pipe_checker_pkg.sv
// Shared constants, entry layout and helpers for the pipeline result checker.
package pipe_check_pkg;

  // Width of the free-running timestamp stored alongside each expectation.
  localparam int TS_W = 8;

  // FIFO entry layout is {exp[W-1:0], stamp[TS_W-1:0]}. W is a module
  // parameter, so the layout is described by widths, not a packed struct.
  function automatic int entry_w(input int w);
    return w + TS_W;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/pipe_checker_sync_fifo.sv
// Zero-read-latency synchronous FIFO: the head entry is visible on dout
// combinationally. A pop on empty is ignored; a push on full is dropped
// unless a pop frees the slot in the same cycle.
module sync_fifo
  import pipe_check_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pipe_checker.sv
// Result monitor for an AND-terminated L-stage pipeline: queues a&b with a
// timestamp on the input side, pops and checks data and latency on the
// output side, and keeps saturating counters plus sticky error flags.
module pipe_checker
  import pipe_check_pkg::*;
#(
  parameter int W     = 8,
  parameter int L     = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  input  logic                     valid_out,
  input  logic [W-1:0]             out,
  input  logic                     clear,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     first_err,
  output logic [W-1:0]             first_exp,
  output logic [W-1:0]             first_got,
  output logic                     lat_err,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     idle
);

  localparam int EW = entry_w(W);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             first_err_q, first_err_d;
  logic [W-1:0]     first_exp_q, first_exp_d;
  logic [W-1:0]     first_got_q, first_got_d;
  logic             lat_err_q, lat_err_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [EW-1:0]    fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic             pop_req;
  logic [W-1:0]     head_exp;
  logic [TS_W-1:0]  head_stamp;
  logic [TS_W-1:0]  age;
  logic             data_ok;
  logic             lat_ok;

  assign pop_req    = valid_out & ~fifo_empty;
  assign head_exp   = fifo_dout[EW-1 -: W];
  assign head_stamp = fifo_dout[TS_W-1:0];
  assign age        = ts_q - head_stamp;  // modulo-256 elapsed cycles
  assign data_ok    = (out == head_exp);
  assign lat_ok     = (age == TS_W'(L));

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (valid_in),
    .pop   (pop_req),
    .din   ({a & b, ts_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state for timestamp, counters and sticky flags; clear beats any event.
  always_comb begin
    ts_d        = ts_q + TS_W'(1);
    match_d     = match_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    lat_err_d   = lat_err_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    if (clear) begin
      match_d     = '0;
      err_d       = '0;
      first_err_d = 1'b0;
      first_exp_d = '0;
      first_got_d = '0;
      lat_err_d   = 1'b0;
      ovf_d       = 1'b0;
      udf_d       = 1'b0;
    end else begin
      if (pop_req) begin
        if (data_ok && lat_ok) match_d = CNT_W'(sat_inc(32'(match_q), CNT_W));
        else                   err_d   = CNT_W'(sat_inc(32'(err_q), CNT_W));
        if (!data_ok) begin
          first_err_d = 1'b1;
          if (!first_err_q) begin
            first_exp_d = head_exp;
            first_got_d = out;
          end
        end
        if (!lat_ok) lat_err_d = 1'b1;
      end
      if (valid_out && fifo_empty)             udf_d = 1'b1;
      if (valid_in && fifo_full && !pop_req)   ovf_d = 1'b1;
    end
  end

  // Checker state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q        <= '0;
      match_q     <= '0;
      err_q       <= '0;
      first_err_q <= 1'b0;
      first_exp_q <= '0;
      first_got_q <= '0;
      lat_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      match_q     <= match_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
      lat_err_q   <= lat_err_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign match_cnt = match_q;
  assign err_cnt   = err_q;
  assign first_err = first_err_q;
  assign first_exp = first_exp_q;
  assign first_got = first_got_q;
  assign lat_err   = lat_err_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign pending   = fifo_count;
  assign idle      = (fifo_count == '0);

endmodule

// File: tb/tb_pipe_checker.sv
// Directed bench for pipe_checker with a bench-side model of an ideal
// L-cycle AND pipeline and hand-computed expected values.
module tb_pipe_checker;

  localparam int W     = 8;
  localparam int L     = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             valid_out = 1'b0;
  logic [W-1:0]     out = '0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             first_err;
  logic [W-1:0]     first_exp;
  logic [W-1:0]     first_got;
  logic             lat_err;
  logic             overflow;
  logic             underflow;
  logic [3:0]       pending;
  logic             idle;

  int n_chk = 0;
  int n_bad = 0;

  pipe_checker #(.W(W), .L(L), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .out       (out),
    .clear     (clear),
    .match_cnt (match_cnt),
    .err_cnt   (err_cnt),
    .first_err (first_err),
    .first_exp (first_exp),
    .first_got (first_got),
    .lat_err   (lat_err),
    .overflow  (overflow),
    .underflow (underflow),
    .pending   (pending),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Drive n inputs a=0xF0+i, b=0x3C back to back and return each result at
  // i+L (i+L+1 for index 'late'); result index 'bad' is replaced by badval.
  task automatic stream(input int n, input int bad, input logic [7:0] badval, input int late);
    logic [7:0] ov [64];
    bit         ovv [64];
    logic [7:0] av;
    int         oc;
    for (int c = 0; c < 64; c++) begin
      ovv[c] = 1'b0;
      ov[c]  = '0;
    end
    for (int i = 0; i < n; i++) begin
      av = 8'hF0 + 8'(i);
      oc = i + L + ((i == late) ? 1 : 0);
      ovv[oc] = 1'b1;
      ov[oc]  = (i == bad) ? badval : (av & 8'h3C);
    end
    for (int c = 0; c < n + L + 2; c++) begin
      valid_in  = (c < n);
      a         = (c < n) ? 8'hF0 + 8'(c) : 8'h00;
      b         = 8'h3C;
      valid_out = ovv[c];
      out       = ov[c];
      tick();
    end
    valid_in  = 1'b0;
    valid_out = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_match", 32'(match_cnt), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_first_err", 32'(first_err), 0);
    chk("rst_first_exp", 32'(first_exp), 0);
    chk("rst_first_got", 32'(first_got), 0);
    chk("rst_flags", 32'({lat_err, overflow, underflow}), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_idle", 32'(idle), 1);

    // Clean stream of 20 at full throughput
    stream(20, -1, 8'h00, -1);
    chk("clean_match", 32'(match_cnt), 20);
    chk("clean_err", 32'(err_cnt), 0);
    chk("clean_flags", 32'({first_err, lat_err, overflow, underflow}), 0);
    chk("clean_idle", 32'(idle), 1);

    // Data errors: 5th result 0x34 -> 0x00, then a later 0x30 -> 0xFF
    pulse_clear();
    chk("clr_match", 32'(match_cnt), 0);
    stream(5, 4, 8'h00, -1);
    chk("derr1_err", 32'(err_cnt), 1);
    chk("derr1_match", 32'(match_cnt), 4);
    chk("derr1_first_err", 32'(first_err), 1);
    chk("derr1_first_exp", 32'(first_exp), 32'h34);
    chk("derr1_first_got", 32'(first_got), 32'h00);
    chk("derr1_lat_err", 32'(lat_err), 0);
    stream(5, 2, 8'hFF, -1);
    chk("derr2_err", 32'(err_cnt), 2);
    chk("derr2_match", 32'(match_cnt), 8);
    chk("derr2_first_exp", 32'(first_exp), 32'h34);
    chk("derr2_first_got", 32'(first_got), 32'h00);

    // Latency error: one correct result at t+5
    pulse_clear();
    chk("clr_first_err", 32'(first_err), 0);
    chk("clr_first_exp", 32'(first_exp), 0);
    stream(1, -1, 8'h00, 0);
    chk("lat_lat_err", 32'(lat_err), 1);
    chk("lat_err_cnt", 32'(err_cnt), 1);
    chk("lat_first_err", 32'(first_err), 0);
    chk("lat_match", 32'(match_cnt), 0);

    // Underflow: valid_out with nothing pending
    pulse_clear();
    valid_out = 1'b1;
    out = 8'h55;
    tick();
    valid_out = 1'b0;
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_err", 32'(err_cnt), 0);
    chk("udf_match", 32'(match_cnt), 0);

    // Overflow: fill to 8, push+pop at full, then push alone
    pulse_clear();
    for (int k = 0; k < 8; k++) begin
      valid_in = 1'b1;
      a = 8'(k);
      b = 8'hFF;
      tick();
    end
    valid_in = 1'b0;
    chk("full_ovf", 32'(overflow), 0);
    chk("full_pending", 32'(pending), 8);
    valid_in = 1'b1;
    valid_out = 1'b1;
    out = 8'h00;
    tick();
    valid_out = 1'b0;
    chk("fullpp_ovf", 32'(overflow), 0);
    chk("fullpp_pending", 32'(pending), 8);
    tick();
    valid_in = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_pending", 32'(pending), 8);

    // Clear with entries pending, then mid-stream reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_pending", 32'(pending), 0);
    chk("rst2_ovf", 32'(overflow), 0);
    valid_out = 1'b1;
    out = 8'h00;
    tick();
    valid_out = 1'b0;
    stream(2, -1, 8'h00, -1);
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1;
      a = 8'hA5;
      b = 8'h0F;
      tick();
    end
    valid_in = 1'b0;
    chk("pre_clr_match", 32'(match_cnt), 2);
    chk("pre_clr_udf", 32'(underflow), 1);
    chk("pre_clr_pending", 32'(pending), 3);
    pulse_clear();
    chk("clr3_match", 32'(match_cnt), 0);
    chk("clr3_udf", 32'(underflow), 0);
    chk("clr3_pending", 32'(pending), 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst3_pending", 32'(pending), 0);
    chk("rst3_idle", 32'(idle), 1);
    for (int k = 0; k < 3; k++) begin
      valid_out = 1'b1;
      out = 8'h05;
      tick();
    end
    valid_out = 1'b0;
    chk("late_udf", 32'(underflow), 1);
    chk("late_err", 32'(err_cnt), 0);
    chk("late_match", 32'(match_cnt), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_checker.md
# pipe_checker

Self-checking result monitor for the `andg`-terminated L-stage pipeline. It observes the pipeline input side (`valid_in`, `a`, `b`) and queues the expected result `a & b` together with a timestamp. It observes the output side (`valid_out`, `out`) and pops, compares and times every result. It sits beside the pipeline in the Verilator test top and exposes counters and sticky error flags readable through `verilator_me` probes.

## Interface
- `W`, 8, operand/result width; must match the pipeline.
- `L`, 4, nominal pipeline latency in cycles; 1 ≤ L ≤ 255.
- `DEPTH`, 8, expected-result FIFO depth; power of two, ≥ L+1.
- `CNT_W`, 16, width of match/error counters.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `valid_in`  in  1  stimulus valid at the pipeline input.
- `a`  in  W  operand A at the pipeline input.
- `b`  in  W  operand B at the pipeline input.
- `valid_out`  in  1  result valid from the pipeline.
- `out`  in  W  result from the pipeline.
- `clear`  in  1  synchronous clear of counters and sticky flags; FIFO untouched.
- `match_cnt`  out  CNT_W  number of correct results, saturating.
- `err_cnt`  out  CNT_W  number of data or latency mismatches, saturating.
- `first_err`  out  1  sticky; a mismatch has occurred.
- `first_exp`  out  W  expected value at the first mismatch.
- `first_got`  out  W  received value at the first mismatch.
- `lat_err`  out  1  sticky; a result arrived with latency ≠ L.
- `overflow`  out  1  sticky; push attempted while FIFO full with no pop.
- `underflow`  out  1  sticky; `valid_out` seen with FIFO empty.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `idle`  out  1  `pending == 0`.

## Operation
- Free-running timestamp `ts`, 8 bits, increments every cycle and wraps modulo 256.
- **Push:** when `valid_in`, write `{a & b, ts}` to the FIFO.
- **Pop:** when `valid_out` and the FIFO is non-empty, pop the head and perform two checks.
  - Data check: `out == exp`.
  - Latency check: `(ts - stamp) mod 256 == L`.
- **Result of a pop:**
  - Both checks pass: `match_cnt` += 1.
  - Either check fails: `err_cnt` += 1.
  - Data check fails: set `first_err`.
  - Latency check fails: set `lat_err`.
  - A data and latency failure in the same pop counts once.
- **First-error capture:** `first_exp` and `first_got` are latched only on the first data mismatch, i.e. while `first_err` is 0.
- **Underflow:** `valid_out` with the FIFO empty sets `underflow`. No compare is made and no counter changes.
- **Simultaneous push and pop:**
  - Both are performed.
  - At full: the pop frees the slot and the push is accepted, with no overflow.
  - At empty: the pop is an underflow and the push is still accepted.
- **Overflow:** push while full without a pop sets `overflow`, and the new entry is dropped.
- **Saturation:** counters stop at 2^CNT_W−1.
- **`clear`:** zeroes counters, `first_err`, `first_exp`, `first_got`, `lat_err`, `overflow` and `underflow`. It does not flush the FIFO.
  - An event in the same cycle as `clear` is lost. `clear` wins.
- **Reset:** flushes the FIFO and zeroes `ts`, all counters and all flags.

## Timing
- All outputs are registered. Reset value of every output is 0, except `idle` = 1.
- Counters and flags reflect a `valid_out` event in the cycle after it.
- `pending` reflects a push or pop in the cycle after it.
- The FIFO has zero read latency: the head is combinationally visible, so the compare happens in the same cycle as `valid_out`.
- For a well-behaved pipeline, `valid_out` for an input at cycle t arrives at t+L. The checker is then lossless at full throughput, one transaction per cycle.
- Reset asserted mid-stream discards all queued expectations. Results emerging after reset deassert count as underflow.

## Structure
- Package `pipe_check_pkg` holds:
  - `TS_W = 8`
  - the entry type `{exp[W-1:0], stamp[TS_W-1:0]}`, expressed as width constants because W is a parameter
  - the saturating-increment function
- Sub-module `sync_fifo`:
  - parameters: width and depth
  - ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`
  - synchronous active-low reset, same `clk`/`rst_n`

## Test plan
- **Clean stream:** L=4. Drive 20 back-to-back inputs `a=0xF0+i`, `b=0x3C`; return correct results at t+4. Required: `match_cnt`=20, `err_cnt`=0, no flags, `idle`=1 at the end.
- **Single data error:** corrupt the 5th result to `0x00` (expected `0x34`). Required: `err_cnt`=1, `first_err`=1, `first_exp`=0x34, `first_got`=0x00. A second corruption changes `err_cnt` to 2 and leaves `first_exp`/`first_got` unchanged.
- **Latency error:** return one correct result at t+5. Required: `lat_err`=1, `err_cnt`=1, `first_err`=0.
- **Underflow and overflow:** assert `valid_out` with no pending entries → `underflow`=1. With DEPTH=8, push 9 entries with no pops → `overflow`=1 and `pending`=8.
- **Clear and reset:** with 3 entries pending and nonzero counters, pulse `clear` → counters and flags 0, `pending`=3. Then pulse `rst_n` low for 1 cycle → `pending`=0, `idle`=1. The late results that follow set `underflow`.
